// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage scoreboard hazard unit.
package hazard_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;
  localparam int LAT_MUL  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALLED = 2'd1,
    ERROR   = 2'd2
  } wd_state_e;

endpackage

// File: rtl/hazard_lat_counter.sv
// Remaining-latency counter for one architectural register.
// Priority: flush, issue (longest latency wins), early writeback, decrement.
module hazard_lat_counter #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             issue_hit,
  input  logic             wb_hit,
  input  logic [LAT_W-1:0] issue_lat,
  output logic [LAT_W-1:0] cnt
);

  logic [LAT_W-1:0] cnt_dec;
  logic [LAT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_dec = (cnt == '0) ? '0 : cnt - LAT_W'(1);
    cnt_nxt = cnt_dec;
    if (flush) begin
      cnt_nxt = '0;
    end else if (issue_hit) begin
      cnt_nxt = (issue_lat > cnt_dec) ? issue_lat : cnt_dec;
    end else if (wb_hit) begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Scoreboard hazard unit: per-register latency tracking, combinational ID stall,
// consecutive-stall watchdog. Define HAZ_PERF_CNT_EN to add stall performance counters.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter  int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter  int LAT_W       = 3,
  parameter  int FWD_SLACK   = 1,
  parameter  int MAX_STALL   = 15,
  parameter  int STALL_CNT_W = 4,
  localparam int NUM_REGS    = 2 ** REG_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic [REG_ADDR_W-1:0]  issue_rd,
  input  logic [LAT_W-1:0]       issue_lat,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic [REG_ADDR_W-1:0]  id_rt,
  input  logic                   id_rs_used,
  input  logic                   id_rt_used,
  input  logic                   wb_valid,
  input  logic [REG_ADDR_W-1:0]  wb_rd,
  input  logic                   flush,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_run,
  output logic                   hazard_err,
  output logic [NUM_REGS-1:0]    busy_vec
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]            perf_stall_cycles,
  output logic [31:0]            perf_stall_events
`endif
);

  localparam logic [LAT_W-1:0]       SLACK   = LAT_W'(FWD_SLACK);
  localparam logic [STALL_CNT_W-1:0] RUN_MAX = '1;
  localparam logic [STALL_CNT_W-1:0] RUN_ERR = STALL_CNT_W'(MAX_STALL);

  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic             rs_haz;
  logic             rt_haz;
  logic             eff_issue;

  // Stall as soon as a source cannot be forwarded yet; r0 is never a hazard.
  assign rs_haz    = id_rs_used && (id_rs != '0) && (cnt[id_rs] > SLACK);
  assign rt_haz    = id_rt_used && (id_rt != '0) && (cnt[id_rt] > SLACK);
  assign stall     = rs_haz || rt_haz;
  assign eff_issue = issue_valid && !stall && !flush;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic issue_hit;
    logic wb_hit;

    assign issue_hit = eff_issue && (issue_rd == REG_ADDR_W'(i)) && (issue_rd != '0);
    assign wb_hit    = wb_valid && (wb_rd == REG_ADDR_W'(i));

    hazard_lat_counter #(
      .LAT_W(LAT_W)
    ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .issue_hit(issue_hit),
      .wb_hit   (wb_hit),
      .issue_lat(issue_lat),
      .cnt      (cnt[i])
    );

    assign busy_vec[i] = (cnt[i] != '0);
  end

  wd_state_e              state_q;
  wd_state_e              state_d;
  logic [STALL_CNT_W-1:0] run_q;
  logic [STALL_CNT_W-1:0] run_d;
  logic [STALL_CNT_W-1:0] run_inc;

  assign run_inc = (run_q == RUN_MAX) ? run_q : run_q + STALL_CNT_W'(1);

  // Run length follows stall in every state; only the state decides stickiness.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (flush) begin
      state_d = IDLE;
      run_d   = '0;
    end else begin
      run_d = stall ? run_inc : '0;
      unique case (state_q)
        IDLE: begin
          if (stall) state_d = (run_d == RUN_ERR) ? ERROR : STALLED;
        end
        STALLED: begin
          if (!stall)                state_d = IDLE;
          else if (run_d == RUN_ERR) state_d = ERROR;
        end
        ERROR:   state_d = ERROR;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  assign stall_run  = run_q;
  assign hazard_err = (state_q == ERROR);

`ifdef HAZ_PERF_CNT_EN
  // Free-running statistics; flush deliberately leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_stall_events <= '0;
    end else begin
      if (stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (state_q == IDLE && state_d != IDLE) perf_stall_events <= perf_stall_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit with a cycle-level scoreboard model.
module tb_hazard_scoreboard_unit;
  import hazard_pkg::*;

  localparam int RA = 5;
  localparam int LW = 5;
  localparam int NR = 32;

  logic          clk;
  logic          rst_n;
  logic          issue_valid;
  logic [RA-1:0] issue_rd;
  logic [LW-1:0] issue_lat;
  logic [RA-1:0] id_rs;
  logic [RA-1:0] id_rt;
  logic          id_rs_used;
  logic          id_rt_used;
  logic          wb_valid;
  logic [RA-1:0] wb_rd;
  logic          flush;
  logic          stall;
  logic [3:0]    stall_run;
  logic          hazard_err;
  logic [NR-1:0] busy_vec;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]   perf_stall_cycles;
  logic [31:0]   perf_stall_events;
`endif

  int total = 0;
  int bad   = 0;

  hazard_scoreboard_unit #(
    .REG_ADDR_W (RA),
    .LAT_W      (LW),
    .FWD_SLACK  (1),
    .MAX_STALL  (15),
    .STALL_CNT_W(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_lat  (issue_lat),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .flush      (flush),
    .stall      (stall),
    .stall_run  (stall_run),
    .hazard_err (hazard_err),
    .busy_vec   (busy_vec)
`ifdef HAZ_PERF_CNT_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_stall_events(perf_stall_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model and scoreboard queue
  typedef struct packed {
    logic [NR-1:0] busy;
    logic [3:0]    run;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [LW-1:0] m_cnt [NR];
  int            m_state;
  logic [3:0]    m_run;

  function automatic logic m_stall_f();
    logic a;
    logic b;
    a = id_rs_used && (id_rs != 0) && (m_cnt[id_rs] > 5'd1);
    b = id_rt_used && (id_rt != 0) && (m_cnt[id_rt] > 5'd1);
    return a || b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_cnt[i] = '0;
    m_state = 0;
    m_run   = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic          s;
    logic          eff;
    logic [LW-1:0] dec;
    logic [LW-1:0] nx [NR];
    logic [NR-1:0] bz;
    exp_t          e;
    s   = m_stall_f();
    eff = issue_valid && !s && !flush;
    for (int i = 0; i < NR; i++) begin
      dec = (m_cnt[i] == 0) ? '0 : m_cnt[i] - 5'd1;
      if (flush)                                     nx[i] = '0;
      else if (eff && issue_rd == 5'(i) && i != 0)   nx[i] = (issue_lat > dec) ? issue_lat : dec;
      else if (wb_valid && wb_rd == 5'(i))           nx[i] = '0;
      else                                           nx[i] = dec;
    end
    if (flush) begin
      m_state = 0;
      m_run   = '0;
    end else if (!s) begin
      m_run   = '0;
      m_state = (m_state == 2) ? 2 : 0;
    end else begin
      m_run   = (m_run == 4'd15) ? 4'd15 : m_run + 4'd1;
      m_state = (m_state == 2 || m_run == 4'd15) ? 2 : 1;
    end
    for (int i = 0; i < NR; i++) begin
      m_cnt[i] = nx[i];
      bz[i]    = (nx[i] != 0);
    end
    e.busy = bz;
    e.run  = m_run;
    e.err  = (m_state == 2);
    exp_q.push_back(e);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        total++;
        if (busy_vec !== mon_e.busy) begin
          bad++;
          $display("FAIL sb_busy t=%0t got=%h exp=%h", $time, busy_vec, mon_e.busy);
        end
        total++;
        if (stall_run !== mon_e.run) begin
          bad++;
          $display("FAIL sb_run t=%0t got=%0d exp=%0d", $time, stall_run, mon_e.run);
        end
        total++;
        if (hazard_err !== mon_e.err) begin
          bad++;
          $display("FAIL sb_err t=%0t got=%0b exp=%0b", $time, hazard_err, mon_e.err);
        end
        total++;
        if (stall !== m_stall_f()) begin
          bad++;
          $display("FAIL sb_stall t=%0t got=%0b exp=%0b", $time, stall, m_stall_f());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    issue_valid = 1'b0; issue_rd = '0; issue_lat = '0;
    id_rs = '0; id_rt = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
  endtask

  task automatic drain(input int n);
    idle_in();
    repeat (n) tick();
  endtask

  task automatic do_issue(input int rd, input int lat);
    issue_valid = 1'b1;
    issue_rd    = RA'(rd);
    issue_lat   = LW'(lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_in();
    repeat (3) tick();
    total++; if (stall !== 1'b0)      begin bad++; $display("FAIL rst_stall got=%0b exp=0", stall); end
    total++; if (stall_run !== 4'd0)  begin bad++; $display("FAIL rst_run got=%0d exp=0", stall_run); end
    total++; if (hazard_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", hazard_err); end
    total++; if (busy_vec !== '0)     begin bad++; $display("FAIL rst_busy got=%h exp=0", busy_vec); end
    rst_n = 1'b1;
    repeat (2) tick();
    total++; if (busy_vec !== '0)     begin bad++; $display("FAIL rst_rel_busy got=%h exp=0", busy_vec); end
  endtask

  task automatic test_load_use();
    do_issue(5, LAT_LOAD);
    tick();
    issue_valid = 1'b0;
    id_rs = 5'd5; id_rs_used = 1'b1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall_on got=%0b exp=1", stall); end
    tick();
    total++; if (stall !== 1'b0)     begin bad++; $display("FAIL lu_stall_off got=%0b exp=0", stall); end
    total++; if (stall_run !== 4'd1) begin bad++; $display("FAIL lu_run1 got=%0d exp=1", stall_run); end
    tick();
    total++; if (stall_run !== 4'd0) begin bad++; $display("FAIL lu_run0 got=%0d exp=0", stall_run); end
    drain(3);
  endtask

  task automatic test_alu_fwd();
    do_issue(0, LAT_MUL);
    tick();
    do_issue(7, LAT_ALU);
    id_rs = 5'd0; id_rs_used = 1'b1;
    #1;
    total++; if (stall !== 1'b0)       begin bad++; $display("FAIL r0_stall got=%0b exp=0", stall); end
    total++; if (busy_vec[0] !== 1'b0) begin bad++; $display("FAIL r0_busy got=%0b exp=0", busy_vec[0]); end
    tick();
    issue_valid = 1'b0;
    id_rt = 5'd7; id_rt_used = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%0b exp=0", stall); end
    drain(3);
  endtask

  task automatic test_waw();
    int n;
    do_issue(3, LAT_MUL);
    tick();
    do_issue(3, LAT_ALU);
    tick();
    issue_valid = 1'b0;
    id_rs = 5'd3; id_rs_used = 1'b1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (stall !== 1'b1) break;
      n++;
      tick();
    end
    total++; if (n !== 2) begin bad++; $display("FAIL waw_stall_len got=%0d exp=2", n); end
    drain(4);
    do_issue(3, LAT_MUL);
    wb_valid = 1'b1; wb_rd = 5'd3;
    tick();
    issue_valid = 1'b0; wb_valid = 1'b0;
    id_rs = 5'd3; id_rs_used = 1'b1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (stall !== 1'b1) break;
      n++;
      tick();
    end
    total++; if (n !== 3) begin bad++; $display("FAIL iss_wb_stall_len got=%0d exp=3", n); end
    drain(4);
    do_issue(4, LAT_MUL);
    tick();
    issue_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd4;
    tick();
    wb_valid = 1'b0;
    total++; if (busy_vec[4] !== 1'b0) begin bad++; $display("FAIL wb_clear got=%0b exp=0", busy_vec[4]); end
    drain(3);
  endtask

  task automatic test_back_to_back();
    do_issue(6, LAT_LOAD);
    tick();
    do_issue(8, LAT_MUL);
    id_rs = 5'd6; id_rs_used = 1'b1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL b2b_stall got=%0b exp=1", stall); end
    tick();
    issue_valid = 1'b0; id_rs_used = 1'b0;
    total++; if (busy_vec[8] !== 1'b0) begin bad++; $display("FAIL b2b_drop got=%0b exp=0", busy_vec[8]); end
    drain(3);
  endtask

  task automatic test_flush();
    do_issue(9, LAT_MUL);
    tick();
    issue_valid = 1'b0;
    id_rs = 5'd9; id_rs_used = 1'b1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL fl_pre_stall got=%0b exp=1", stall); end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    total++; if (busy_vec !== '0)    begin bad++; $display("FAIL fl_busy got=%h exp=0", busy_vec); end
    total++; if (stall !== 1'b0)     begin bad++; $display("FAIL fl_stall got=%0b exp=0", stall); end
    total++; if (stall_run !== 4'd0) begin bad++; $display("FAIL fl_run got=%0d exp=0", stall_run); end
    id_rs_used = 1'b0;
    do_issue(10, LAT_MUL);
    flush = 1'b1;
    tick();
    idle_in();
    total++; if (busy_vec !== '0) begin bad++; $display("FAIL fl_issue_drop got=%h exp=0", busy_vec); end
    drain(2);
  endtask

  task automatic test_watchdog();
    do_issue(11, 18);
    tick();
    issue_valid = 1'b0;
    id_rs = 5'd11; id_rs_used = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 14) begin
        total++; if (hazard_err !== 1'b0) begin bad++; $display("FAIL wd_err14 got=%0b exp=0", hazard_err); end
      end
      if (k == 15) begin
        total++; if (hazard_err !== 1'b1) begin bad++; $display("FAIL wd_err15 got=%0b exp=1", hazard_err); end
        total++; if (stall_run !== 4'd15) begin bad++; $display("FAIL wd_run15 got=%0d exp=15", stall_run); end
      end
    end
    total++; if (stall_run !== 4'd15) begin bad++; $display("FAIL wd_run_sat got=%0d exp=15", stall_run); end
    total++; if (stall !== 1'b0)      begin bad++; $display("FAIL wd_stall_end got=%0b exp=0", stall); end
    tick();
    total++; if (stall_run !== 4'd0)  begin bad++; $display("FAIL wd_run_drop got=%0d exp=0", stall_run); end
    total++; if (hazard_err !== 1'b1) begin bad++; $display("FAIL wd_sticky got=%0b exp=1", hazard_err); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (hazard_err !== 1'b0) begin bad++; $display("FAIL wd_flush_clr got=%0b exp=0", hazard_err); end
    drain(2);
  endtask

  task automatic test_async_reset();
    do_issue(12, LAT_MUL);
    tick();
    issue_valid = 1'b0;
    id_rs = 5'd12; id_rs_used = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (stall !== 1'b0)      begin bad++; $display("FAIL ar_stall got=%0b exp=0", stall); end
    total++; if (busy_vec !== '0)     begin bad++; $display("FAIL ar_busy got=%h exp=0", busy_vec); end
    total++; if (stall_run !== 4'd0)  begin bad++; $display("FAIL ar_run got=%0d exp=0", stall_run); end
    total++; if (hazard_err !== 1'b0) begin bad++; $display("FAIL ar_err got=%0b exp=0", hazard_err); end
    idle_in();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic test_perf();
    do_issue(5, LAT_LOAD);
    tick();
    issue_valid = 1'b0;
    id_rs = 5'd5; id_rs_used = 1'b1;
    repeat (2) tick();
    id_rs_used = 1'b0;
    tick();
    do_issue(6, LAT_MUL);
    tick();
    issue_valid = 1'b0;
    id_rt = 5'd6; id_rt_used = 1'b1;
    repeat (4) tick();
    id_rt_used = 1'b0;
    tick();
    total++; if (perf_stall_cycles !== 32'd4) begin bad++; $display("FAIL perf_cycles got=%0d exp=4", perf_stall_cycles); end
    total++; if (perf_stall_events !== 32'd2) begin bad++; $display("FAIL perf_events got=%0d exp=2", perf_stall_events); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    total++; if (perf_stall_cycles !== 32'd4) begin bad++; $display("FAIL perf_cycles_fl got=%0d exp=4", perf_stall_cycles); end
    total++; if (perf_stall_events !== 32'd2) begin bad++; $display("FAIL perf_events_fl got=%0d exp=2", perf_stall_events); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    idle_in();
    test_reset();
    test_load_use();
    test_alu_fwd();
    test_waw();
    test_back_to_back();
    test_flush();
    test_watchdog();
    test_async_reset();
`ifdef HAZ_PERF_CNT_EN
    test_perf();
`endif
    drain(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
